// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, FSM states and
// header field positions.
package uart_cmd_pkg;

   localparam logic [3:0] OP_WR16 = 4'h1;
   localparam logic [3:0] OP_WR8  = 4'h2;

   localparam int HDR_BIT = 8;
   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DATA_HI = 2'd1,
      DATA_LO = 2'd2,
      COMMIT  = 2'd3
   } state_t;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-frame watchdog: counts enabled cycles and flags when the limit is hit.
module uart_cmd_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses header/data frames from the UART receiver and issues single-cycle
// writes into the VGA configuration register file.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned ADDR_W         = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [8:0]        frame,
   input  logic              frame_valid,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [15:0]       reg_wdata,
   output logic              reg_we,
   output logic              err,
   output logic              busy,
   output logic [7:0]        cmd_cnt
);

   state_t            state;
   logic              wr8_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       shift;
   logic              err_pend;

   logic              hdr;
   logic [3:0]        hdr_op;
   logic              hdr_legal;
   state_t            hdr_next;
   logic              in_pkt;
   logic              tmr_clr;
   logic              expire;

   always_comb begin
      hdr       = frame[HDR_BIT];
      hdr_op    = frame[OP_MSB:OP_LSB];
      hdr_legal = (hdr_op == OP_WR16) || (hdr_op == OP_WR8);
      hdr_next  = (hdr_op == OP_WR8) ? DATA_LO : DATA_HI;
      in_pkt    = (state == DATA_HI) || (state == DATA_LO);
      tmr_clr   = frame_valid || !in_pkt;
   end

   uart_cmd_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (tmr_clr),
      .en    (in_pkt),
      .expire(expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr8_q     <= 1'b0;
         addr_q    <= '0;
         shift     <= '0;
         err_pend  <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         cmd_cnt   <= '0;
      end else begin
         reg_we   <= 1'b0;
         err      <= err_pend;
         err_pend <= 1'b0;
         case (state)
            IDLE, COMMIT: begin
               if (state == COMMIT) begin
                  reg_we    <= 1'b1;
                  reg_addr  <= addr_q;
                  reg_wdata <= shift;
                  cmd_cnt   <= cmd_cnt + 8'd1;
               end
               state <= IDLE;
               busy  <= 1'b0;
               if (frame_valid) begin
                  if (hdr && hdr_legal) begin
                     state  <= hdr_next;
                     busy   <= 1'b1;
                     addr_q <= frame[ADDR_W-1:0];
                     wr8_q  <= (hdr_op == OP_WR8);
                  end else if (state == COMMIT) begin
                     // Defer the error one cycle so it never overlaps reg_we.
                     err_pend <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            DATA_HI, DATA_LO: begin
               if (frame_valid) begin
                  if (hdr) begin
                     err   <= 1'b1;
                     state <= hdr_legal ? hdr_next : IDLE;
                     busy  <= hdr_legal;
                     if (hdr_legal) begin
                        addr_q <= frame[ADDR_W-1:0];
                        wr8_q  <= (hdr_op == OP_WR8);
                     end
                  end else if (state == DATA_HI) begin
                     shift[15:8] <= frame[7:0];
                     state       <= DATA_LO;
                  end else begin
                     shift[7:0] <= frame[7:0];
                     if (wr8_q) begin
                        shift[15:8] <= 8'h00;
                     end
                     state <= COMMIT;
                     busy  <= 1'b0;
                  end
               end else if (expire) begin
                  err   <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus queues expected writes/errors,
// a negedge monitor pops and compares whenever reg_we or err fires.
module tb_uart_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  frame;
   logic        frame_valid;
   logic [3:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we;
   logic        err;
   logic        busy;
   logic [7:0]  cmd_cnt;

   typedef struct {
      bit          is_err;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [7:0]  cnt;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        mon_e;
   logic [7:0] exp_cnt;
   int         checks = 0;
   int         errors = 0;

   uart_cmd_ctrl #(
      .TIMEOUT_CYCLES(16),
      .ADDR_W        (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame      (frame),
      .frame_valid(frame_valid),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .err        (err),
      .busy       (busy),
      .cmd_cnt    (cmd_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (reg_we && err) begin
            checks++;
            errors++;
            $display("FAIL we_err_overlap: reg_we=%0b err=%0b, required not both high", reg_we, err);
         end
         if (reg_we || err) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: reg_we=%0b err=%0b addr=%0h data=%0h, required no event",
                        reg_we, err, reg_addr, reg_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_err) begin
                  if (!err) begin
                     errors++;
                     $display("FAIL event_err: got write addr=%0h data=%0h, required err pulse",
                              reg_addr, reg_wdata);
                  end
               end else if (!reg_we || reg_addr != mon_e.addr || reg_wdata != mon_e.data
                            || cmd_cnt != mon_e.cnt) begin
                  errors++;
                  $display("FAIL event_wr: got we=%0b addr=%0h data=%0h cnt=%0d, required addr=%0h data=%0h cnt=%0d",
                           reg_we, reg_addr, reg_wdata, cmd_cnt, mon_e.addr, mon_e.data, mon_e.cnt);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [8:0] f);
      frame       = f;
      frame_valid = 1'b1;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
      ev_t e;
      exp_cnt  = exp_cnt + 8'd1;
      e.is_err = 1'b0;
      e.addr   = a;
      e.data   = d;
      e.cnt    = exp_cnt;
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1;
      e.addr   = '0;
      e.data   = '0;
      e.cnt    = '0;
      exp_q.push_back(e);
   endtask

   initial begin
      logic [7:0] b;
      rst         = 1'b1;
      frame       = '0;
      frame_valid = 1'b0;
      exp_cnt     = '0;
      idle(3);
      check("rst_addr", 32'(reg_addr), 32'h0);
      check("rst_wdata", 32'(reg_wdata), 32'h0);
      check("rst_outs", {29'd0, reg_we, err, busy}, 32'h0);
      check("rst_cnt", 32'(cmd_cnt), 32'h0);
      rst = 1'b0;
      idle(2);

      // WR16 back-to-back
      push_wr(4'h3, 16'hABCD);
      drive(9'h113);
      check("busy_wr16", 32'(busy), 32'h1);
      drive(9'h0AB);
      drive(9'h0CD);
      idle(4);

      // WR8 zero-extended
      push_wr(4'h5, 16'h007F);
      drive(9'h125);
      drive(9'h07F);
      idle(4);
      check("addr_held", 32'(reg_addr), 32'h5);

      // Illegal header then stray data
      push_err();
      drive(9'h1F2);
      check("busy_illegal", 32'(busy), 32'h0);
      idle(3);
      push_err();
      drive(9'h055);
      idle(3);

      // Timeout with silence
      push_err();
      drive(9'h111);
      idle(20);
      check("busy_timeout", 32'(busy), 32'h0);

      // Data arriving on the expiry cycle keeps the packet alive
      drive(9'h111);
      idle(15);
      drive(9'h0AA);
      check("busy_expiry_frame", 32'(busy), 32'h1);
      push_wr(4'h1, 16'hAABB);
      drive(9'h0BB);
      idle(4);

      // Resync on a new header mid-packet
      drive(9'h111);
      drive(9'h0AA);
      push_err();
      drive(9'h122);
      push_wr(4'h2, 16'h0033);
      drive(9'h033);
      idle(4);

      // 256 back-to-back WR8 packets, counter wraps
      for (int i = 0; i < 256; i++) begin
         b = 8'(i);
         push_wr(b[3:0], {8'h00, b});
         drive({5'b10010, b[3:0]});
         drive({1'b0, b});
      end
      idle(4);
      check("cnt_wrap", 32'(cmd_cnt), 32'h4);

      // Reset in the middle of a WR16
      drive(9'h114);
      drive(9'h012);
      check("busy_before_rst", 32'(busy), 32'h1);
      rst = 1'b1;
      idle(1);
      check("mid_rst_addr", 32'(reg_addr), 32'h0);
      check("mid_rst_wdata", 32'(reg_wdata), 32'h0);
      check("mid_rst_outs", {29'd0, reg_we, err, busy}, 32'h0);
      check("mid_rst_cnt", 32'(cmd_cnt), 32'h0);
      exp_cnt = '0;
      rst     = 1'b0;
      idle(2);
      push_wr(4'h3, 16'hABCD);
      drive(9'h113);
      drive(9'h0AB);
      drive(9'h0CD);
      idle(5);
      check("cnt_after_rst", 32'(cmd_cnt), 32'h1);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
